uart_frame_parser: RTL

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser for a UART byte stream: SYNC, LEN, payload[LEN] (+ CHK when
// UART_PARSER_CHECKSUM_EN is defined), buffered and drained over a valid/ready port.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 52080
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data_in,
    input  logic       i_valid_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic [7:0] o_frame_len,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun
);

    localparam int unsigned    IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned    TmoW    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]     MaxLen  = 8'(MAX_LEN);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]     ErrLen  = 2'd1;
    localparam logic [1:0]     ErrTmo  = 2'd3;
`ifdef UART_PARSER_CHECKSUM_EN
    localparam logic [1:0]     ErrChk  = 2'd2;
`endif

    typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StDrain} state_e;

    state_e          st_q, st_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      wr_idx_q, wr_idx_d;
    logic [7:0]      rd_idx_q, rd_idx_d;
    logic [TmoW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            ovr_q, ovr_d;
    logic            mem_we;
    logic [7:0]      mem_q [MAX_LEN];
`ifdef UART_PARSER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic in_frame;
    logic timeout;
    logic in_drain;

    assign in_frame = (st_q == StLen) || (st_q == StPayload) || (st_q == StChk);
    // A byte arriving in the terminal count cycle takes priority over the timeout.
    assign timeout  = in_frame && !i_valid_in && (cnt_q == TmoLast);
    assign in_drain = (st_q == StDrain);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st_q <= StHunt;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        len_d      = len_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        cnt_d      = '0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        ovr_d      = 1'b0;
        mem_we     = 1'b0;
`ifdef UART_PARSER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (in_frame) begin
            cnt_d = i_valid_in ? '0 : cnt_q + TmoW'(1);
        end

        case (st_q)
            StHunt: begin
                if (i_valid_in && (i_data_in == SYNC_BYTE)) begin
                    st_d = StLen;
                end
            end
            StLen: begin
                if (i_valid_in) begin
                    if ((i_data_in == 8'd0) || (i_data_in > MaxLen)) begin
                        st_d       = StHunt;
                        err_d      = 1'b1;
                        err_code_d = ErrLen;
                    end else begin
                        st_d     = StPayload;
                        len_d    = i_data_in;
                        wr_idx_d = 8'd0;
`ifdef UART_PARSER_CHECKSUM_EN
                        sum_d    = i_data_in;
`endif
                    end
                end else if (timeout) begin
                    st_d       = StHunt;
                    err_d      = 1'b1;
                    err_code_d = ErrTmo;
                end
            end
            StPayload: begin
                if (i_valid_in) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + 8'd1;
`ifdef UART_PARSER_CHECKSUM_EN
                    sum_d    = sum_q + i_data_in;
`endif
                    if (wr_idx_q == len_q - 8'd1) begin
`ifdef UART_PARSER_CHECKSUM_EN
                        st_d     = StChk;
`else
                        st_d     = StDrain;
                        rd_idx_d = 8'd0;
`endif
                    end
                end else if (timeout) begin
                    st_d       = StHunt;
                    err_d      = 1'b1;
                    err_code_d = ErrTmo;
                end
            end
`ifdef UART_PARSER_CHECKSUM_EN
            StChk: begin
                if (i_valid_in) begin
                    if (i_data_in == sum_q) begin
                        st_d     = StDrain;
                        rd_idx_d = 8'd0;
                    end else begin
                        st_d       = StHunt;
                        err_d      = 1'b1;
                        err_code_d = ErrChk;
                    end
                end else if (timeout) begin
                    st_d       = StHunt;
                    err_d      = 1'b1;
                    err_code_d = ErrTmo;
                end
            end
`endif
            StDrain: begin
                ovr_d = i_valid_in;
                if (i_ready) begin
                    if (rd_idx_q == len_q - 8'd1) begin
                        st_d = StHunt;
                    end else begin
                        rd_idx_d = rd_idx_q + 8'd1;
                    end
                end
            end
            default: st_d = StHunt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_q      <= 8'd0;
            wr_idx_q   <= 8'd0;
            rd_idx_q   <= 8'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            ovr_q      <= 1'b0;
`ifdef UART_PARSER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ovr_q      <= ovr_d;
`ifdef UART_PARSER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Payload buffer is intentionally left out of reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_idx_q[IdxW-1:0]] <= i_data_in;
        end
    end

    always_comb begin
        o_valid     = in_drain;
        o_data      = in_drain ? mem_q[rd_idx_q[IdxW-1:0]] : 8'h00;
        o_last      = in_drain && (rd_idx_q == len_q - 8'd1);
        o_frame_len = len_q;
        o_err       = err_q;
        o_err_code  = err_code_q;
        o_overrun   = ovr_q;
    end

endmodule
